voice_slot_sched: RTL and testbench

- Time-slot scheduler for the 8-voice PCM datapath.
- Steps a slot counter through voices 0..7, with SLOT_CYCLES clocks per slot.
- Drives the active-low one-hot voice strobes via a 3-to-8 decoder and tracks per-voice key-on state.
- Arbitrates CPU register/RAM access into idle datapath windows.

---
 rtl/voice_sched_pkg.sv | 9 +
 rtl/voice_slot_sched_slot_dec.sv | 16 +
 rtl/voice_slot_sched.sv | 112 +++++++++++
 tb/tb_voice_slot_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_sched_pkg.sv
// Shared widths and types for the 8-voice slot scheduler.
// Type definitions only: no latency, no flow control.
package voice_sched_pkg;
  localparam int NUM_VOICES = 8;
  localparam int SLOT_W     = 3;

  typedef logic [NUM_VOICES-1:0] voice_mask_t;
  typedef logic [SLOT_W-1:0]     slot_t;
endpackage

// File: rtl/voice_slot_sched_slot_dec.sv
// 3-to-8 active-low one-hot decoder with enable; all ones when disabled.
// Combinational, zero latency; no backpressure.
module slot_dec
  import voice_sched_pkg::*;
(
  input  logic [SLOT_W-1:0]     sel,
  input  logic                  en,
  output logic [NUM_VOICES-1:0] dec_n
);

  always_comb begin
    dec_n = '1;
    if (en) dec_n[sel] = 1'b0;
  end

endmodule

// File: rtl/voice_slot_sched.sv
// Voice slot scheduler: slot/phase counters, voice strobes, key-on state, CPU access windows (VOICE_MASK_EN adds voice_mask).
// All outputs registered, one clock after the inputs they depend on; cpu_req is a held level, granted in idle windows only.
module voice_slot_sched
  import voice_sched_pkg::*;
#(
  parameter int SLOT_CYCLES = 4,
  parameter int PH_W        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [NUM_VOICES-1:0] key_on,
  input  logic [NUM_VOICES-1:0] key_off,
  input  logic                  ch_end,
  input  logic                  cpu_req,
`ifdef VOICE_MASK_EN
  input  logic [NUM_VOICES-1:0] voice_mask,
`endif
  output logic [SLOT_W-1:0]     slot,
  output logic [PH_W-1:0]       phase,
  output logic [NUM_VOICES-1:0] strobe_n,
  output logic                  voice_go,
  output logic                  frame_start,
  output logic                  cpu_grant,
  output logic [NUM_VOICES-1:0] active
);

  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(SLOT_CYCLES - 1);
  localparam slot_t           SLOT_LAST = slot_t'(NUM_VOICES - 1);

  logic        running;
  voice_mask_t mask;
  voice_mask_t active_nx;
  voice_mask_t dec_n;
  slot_t       slot_nx;
  logic [PH_W-1:0] phase_nx;
  logic        fs_nx;
  logic        slot_en;
  logic        grant_win;

`ifdef VOICE_MASK_EN
  assign mask = voice_mask;
`else
  assign mask = '0;
`endif

  // key_off beats key_on beats end-of-voice; ch_end only hits the voice in its slot
  always_comb begin
    active_nx = active;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (key_off[i])
        active_nx[i] = 1'b0;
      else if (key_on[i])
        active_nx[i] = 1'b1;
      else if (ch_end && slot == slot_t'(i))
        active_nx[i] = 1'b0;
    end
  end

  // First cycle after run rises restarts at slot 0 phase 0 so frame_start lines up
  always_comb begin
    slot_nx  = '0;
    phase_nx = '0;
    fs_nx    = 1'b0;
    if (run) begin
      if (!running) begin
        fs_nx = 1'b1;
      end else if (phase == PH_LAST) begin
        slot_nx = slot + slot_t'(1);
        fs_nx   = (slot == SLOT_LAST);
      end else begin
        slot_nx  = slot;
        phase_nx = phase + PH_W'(1);
      end
    end
  end

  assign slot_en = run & active_nx[slot_nx] & ~mask[slot_nx];

  // Slot 7's last phase is always a window so a fully loaded frame still serves the CPU
  assign grant_win = run ? ((phase_nx == PH_LAST) && (!slot_en || slot_nx == SLOT_LAST))
                         : 1'b1;

  slot_dec u_slot_dec (
    .sel   (slot_nx),
    .en    (slot_en),
    .dec_n (dec_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      running     <= 1'b0;
      slot        <= '0;
      phase       <= '0;
      strobe_n    <= '1;
      voice_go    <= 1'b0;
      frame_start <= 1'b0;
      cpu_grant   <= 1'b0;
      active      <= '0;
    end else begin
      running     <= run;
      slot        <= slot_nx;
      phase       <= phase_nx;
      strobe_n    <= dec_n;
      voice_go    <= slot_en && (phase_nx == '0);
      frame_start <= fs_nx;
      cpu_grant   <= cpu_req && !cpu_grant && grant_win;
      active      <= active_nx;
    end
  end

endmodule

// File: tb/tb_voice_slot_sched.sv
// Directed bench for voice_slot_sched (SLOT_CYCLES=4): expectations queued with a due cycle, checked at the falling edge.
module tb_voice_slot_sched;

  localparam int SC = 4;
  localparam int PW = 4;

  logic       clk = 1'b0;
  logic       reset, run, ch_end, cpu_req;
  logic [7:0] key_on, key_off;
  logic [7:0] voice_mask;
  logic [2:0] slot;
  logic [PW-1:0] phase;
  logic [7:0] strobe_n, active;
  logic       voice_go, frame_start, cpu_grant;

  voice_slot_sched #(.SLOT_CYCLES(SC), .PH_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .key_on      (key_on),
    .key_off     (key_off),
    .ch_end      (ch_end),
    .cpu_req     (cpu_req),
`ifdef VOICE_MASK_EN
    .voice_mask  (voice_mask),
`endif
    .slot        (slot),
    .phase       (phase),
    .strobe_n    (strobe_n),
    .voice_go    (voice_go),
    .frame_start (frame_start),
    .cpu_grant   (cpu_grant),
    .active      (active)
  );

  always #5 clk = ~clk;

  typedef enum int {F_SLOT, F_PHASE, F_STB, F_GO, F_FS, F_GNT, F_ACT} fld_e;
  typedef struct {
    int         due;
    string      tag;
    fld_e       f;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   r0, r2;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pick(fld_e f);
    case (f)
      F_SLOT:  return {5'd0, slot};
      F_PHASE: return 8'(phase);
      F_STB:   return strobe_n;
      F_GO:    return {7'd0, voice_go};
      F_FS:    return {7'd0, frame_start};
      F_GNT:   return {7'd0, cpu_grant};
      default: return active;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [7:0] obs;
        obs = pick(sb[i].f);
        n_cmp++;
        assert (obs === sb[i].val) else begin
          n_bad++;
          $error("FAIL %s @cyc %0d: observed %h expected %h", sb[i].tag, cyc, obs, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic exp1(input int due, input string tag, input fld_e f, input logic [7:0] v);
    exp_t e;
    e.due = due; e.tag = tag; e.f = f; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_all(input int due, input string tag, input logic [2:0] s, input logic [3:0] p,
                         input logic [7:0] stb, input logic go, input logic fs, input logic gnt,
                         input logic [7:0] act);
    exp1(due, {tag, "_slot"},  F_SLOT,  {5'd0, s});
    exp1(due, {tag, "_phase"}, F_PHASE, {4'd0, p});
    exp1(due, {tag, "_stb"},   F_STB,   stb);
    exp1(due, {tag, "_go"},    F_GO,    {7'd0, go});
    exp1(due, {tag, "_fs"},    F_FS,    {7'd0, fs});
    exp1(due, {tag, "_gnt"},   F_GNT,   {7'd0, gnt});
    exp1(due, {tag, "_act"},   F_ACT,   act);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [7:0] on, input logic [7:0] off, input logic ce);
    key_on = on; key_off = off; ch_end = ce;
    @(posedge clk);
    #1;
    key_on = '0; key_off = '0; ch_end = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b0; ch_end = 1'b0; cpu_req = 1'b0;
    key_on = '0; key_off = '0; voice_mask = '0;
    wait_until(3);
    exp_all(cyc, "reset", 3'd0, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);

    // Idle frames: no strobes, slot steps every 4 clocks, frame_start every 32
    reset = 1'b0; run = 1'b1;
    r0 = cyc + 1;
    for (int k = 0; k < 64; k++) begin
      exp1(r0 + k, "t1_slot",  F_SLOT,  8'((k / SC) % 8));
      exp1(r0 + k, "t1_phase", F_PHASE, 8'(k % SC));
      exp1(r0 + k, "t1_fs",    F_FS,    {7'd0, (k % 32) == 0});
      exp1(r0 + k, "t1_stb",   F_STB,   8'hFF);
      exp1(r0 + k, "t1_go",    F_GO,    8'h00);
    end
    wait_until(r0 + 63);

    // Voices 0 and 2 keyed on at the frame boundary
    for (int k = 64; k < 128; k++) begin
      int s, p;
      s = (k / SC) % 8; p = k % SC;
      exp1(r0 + k, "t2_stb", F_STB, (s == 0) ? 8'hFE : (s == 2) ? 8'hFB : 8'hFF);
      exp1(r0 + k, "t2_go",  F_GO,  {7'd0, (p == 0) && (s == 0 || s == 2)});
      exp1(r0 + k, "t2_act", F_ACT, 8'h05);
    end
    pulse(8'h05, 8'h00, 1'b0);
    wait_until(r0 + 141);

    // key_on + ch_end in slot 3: restart wins, strobe appears mid-slot without voice_go
    exp_all(r0 + 142, "t3_restart", 3'd3, 4'd2, 8'hF7, 1'b0, 1'b0, 1'b0, 8'h0D);
    exp_all(r0 + 143, "t3_hold",    3'd3, 4'd3, 8'hF7, 1'b0, 1'b0, 1'b0, 8'h0D);
    exp_all(r0 + 144, "t3_next",    3'd4, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h0D);
    pulse(8'h08, 8'h00, 1'b1);
    wait_until(r0 + 144);
    exp1(r0 + 145, "t3_onoff_act", F_ACT, 8'h05);
    pulse(8'h08, 8'h08, 1'b0);
    wait_until(r0 + 169);

    // ch_end alone in slot 2 clears voice 2 and drops its strobe next cycle
    exp1(r0 + 169, "t3_chend_pre",  F_STB, 8'hFB);
    exp1(r0 + 170, "t3_chend_stb",  F_STB, 8'hFF);
    exp1(r0 + 170, "t3_chend_act",  F_ACT, 8'h01);
    pulse(8'h00, 8'h00, 1'b1);
    wait_until(r0 + 175);

    // All voices active: grant only at slot 7 phase 3
    exp_all(r0 + 176, "t4_full", 3'd4, 4'd0, 8'hEF, 1'b1, 1'b0, 1'b0, 8'hFF);
    pulse(8'hFE, 8'h00, 1'b0);
    wait_until(r0 + 195);
    cpu_req = 1'b1;
    for (int k = 196; k <= 225; k++)
      exp1(r0 + k, "t4_gnt_full", F_GNT, {7'd0, k == 223});
    exp1(r0 + 223, "t4_gnt_slot", F_SLOT, 8'd7);
    exp1(r0 + 223, "t4_gnt_stb",  F_STB,  8'h7F);
    wait_until(r0 + 224);
    cpu_req = 1'b0;
    wait_until(r0 + 225);

    // Voice 1 off: grant moves to slot 1 phase 3
    exp1(r0 + 226, "t4_act_fd", F_ACT, 8'hFD);
    pulse(8'h00, 8'h02, 1'b0);
    wait_until(r0 + 227);
    cpu_req = 1'b1;
    for (int k = 228; k <= 232; k++)
      exp1(r0 + k, "t4_gnt_fd", F_GNT, {7'd0, k == 231});
    exp1(r0 + 231, "t4_gnt_fd_slot", F_SLOT, 8'd1);
    wait_until(r0 + 232);
    cpu_req = 1'b0;
    wait_until(r0 + 245);

    // run dropped mid slot 5, idle grant, then restart
    exp1(r0 + 245, "t5_pre_stb", F_STB, 8'hDF);
    run = 1'b0;
    exp_all(r0 + 246, "t5_idle", 3'd0, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFD);
    wait_until(r0 + 247);
    cpu_req = 1'b1;
    exp1(r0 + 247, "t5_gnt0", F_GNT, 8'h00);
    exp1(r0 + 248, "t5_gnt1", F_GNT, 8'h01);
    exp1(r0 + 249, "t5_gnt_back2back", F_GNT, 8'h00);
    exp1(r0 + 250, "t5_gnt_after", F_GNT, 8'h00);
    wait_until(r0 + 249);
    cpu_req = 1'b0;
    wait_until(r0 + 250);
    run = 1'b1;
    exp_all(r0 + 251, "t5_rerun",  3'd0, 4'd0, 8'hFE, 1'b1, 1'b1, 1'b0, 8'hFD);
    exp_all(r0 + 252, "t5_rerun1", 3'd0, 4'd1, 8'hFE, 1'b0, 1'b0, 1'b0, 8'hFD);
    exp_all(r0 + 255, "t5_slot1",  3'd1, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFD);
    exp1(r0 + 260, "t6_pre_stb", F_STB, 8'hFB);
    wait_until(r0 + 260);

    // Reset mid-slot aborts the strobe and clears active
    reset = 1'b1;
    exp_all(r0 + 261, "t6_reset", 3'd0, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);
    wait_until(r0 + 261);
    reset = 1'b0;
    r2 = r0 + 262;
    exp_all(r2, "t6_restart", 3'd0, 4'd0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00);
    wait_until(r2);

    // Voice 0 active; with the mask it is skipped and slot 0 becomes a CPU window
`ifdef VOICE_MASK_EN
    voice_mask = 8'h01;
    exp_all(r2 + 1, "t7_mask",  3'd0, 4'd1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h01);
    exp1(r2 + 3, "t7_mask_gnt", F_GNT, 8'h01);
    exp1(r2 + 3, "t7_mask_stb", F_STB, 8'hFF);
    exp1(r2 + 32, "t7_mask_go", F_GO, 8'h00);
    exp1(r2 + 32, "t7_mask_stb32", F_STB, 8'hFF);
    pulse(8'h01, 8'h00, 1'b0);
    cpu_req = 1'b1;
    wait_until(r2 + 4);
    cpu_req = 1'b0;
`else
    exp_all(r2 + 1, "t7_nomask", 3'd0, 4'd1, 8'hFE, 1'b0, 1'b0, 1'b0, 8'h01);
    exp1(r2 + 3, "t7_nomask_gnt3", F_GNT, 8'h00);
    exp1(r2 + 7, "t7_nomask_gnt7", F_GNT, 8'h01);
    exp1(r2 + 7, "t7_nomask_slot", F_SLOT, 8'd1);
    exp1(r2 + 32, "t7_nomask_go", F_GO, 8'h01);
    exp1(r2 + 32, "t7_nomask_stb32", F_STB, 8'hFE);
    pulse(8'h01, 8'h00, 1'b0);
    cpu_req = 1'b1;
    wait_until(r2 + 8);
    cpu_req = 1'b0;
`endif
    wait_until(r2 + 33);
    @(posedge clk);
    #1;

    n_cmp++;
    assert (sb.size() === 0) else begin
      n_bad++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
